// File: rtl/bit_serial_subtractor.sv
// Bit-serial LSB-first subtractor: computes a - b one bit per clock through a
// single full-subtractor cell and a borrow flip-flop. Results (diff,
// borrow_out, overflow) are published only on entry to DONE and held until
// the next operation completes, so partial results never reach the outputs.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full-subtractor difference bit.
  function automatic logic fs_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // Full-subtractor borrow: borrow out of this bit position.
  function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic             borrow_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;
  logic             overflow_r;

  logic             d_s;
  logic             borrow_nxt_s;
  logic [WIDTH-1:0] res_nxt_s;

  // Single subtractor cell operating on the current LSBs of the operand shifters.
  always_comb begin
    d_s          = fs_diff(a_sr_r[0], b_sr_r[0], borrow_r);
    borrow_nxt_s = fs_borrow(a_sr_r[0], b_sr_r[0], borrow_r);
    res_nxt_s    = {d_s, res_sr_r[WIDTH-1:1]};
  end

  // Control FSM, serial datapath and registered result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      count_r      <= CNT_ZERO;
      borrow_r     <= 1'b0;
      a_sr_r       <= '0;
      b_sr_r       <= '0;
      res_sr_r     <= '0;
      a_msb_r      <= 1'b0;
      b_msb_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diff_r       <= '0;
      borrow_out_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            res_sr_r <= '0;
            borrow_r <= 1'b0;
            count_r  <= CNT_ZERO;
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
            busy_r   <= 1'b1;
            state_r  <= SHIFT;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r <= res_nxt_s;
          borrow_r <= borrow_nxt_s;
          if (count_r == LAST_BIT) begin
            // Last bit processed: publish the full result as DONE is entered.
            count_r      <= CNT_ZERO;
            diff_r       <= res_nxt_s;
            borrow_out_r <= borrow_nxt_s;
            overflow_r   <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
            done_r       <= 1'b1;
            state_r      <= DONE;
          end else begin
            count_r <= count_r + CNT_ONE;
            state_r <= SHIFT;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          count_r <= CNT_ZERO;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: an 8-bit instance for the
// directed scenarios and a 3-bit instance for an exhaustive sweep. Expected
// results are pushed to scoreboard queues at issue and popped at done.
module tb_bit_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  logic start8, start3;
  logic [7:0] a8, b8, diff8;
  logic [2:0] a3, b3, diff3;
  logic busy8, done8, bout8, ovf8;
  logic busy3, done3, bout3, ovf3;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb8[$];
  logic [4:0] sb3[$];
  logic [7:0] held8;

  always #5 clk = ~clk;

  bit_serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
    .borrow_out(bout8), .overflow(ovf8)
  );

  bit_serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3),
    .borrow_out(bout3), .overflow(ovf3)
  );

  // Reference for 8 bits: {diff, borrow_out, overflow}
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x - y;
    return {d, (x < y), ((x[7] != y[7]) && (d[7] != x[7]))};
  endfunction

  // Reference for 3 bits using signed integer range for overflow
  function automatic logic [4:0] model3(input logic [2:0] x, input logic [2:0] y);
    int sx, sy, sr;
    logic [2:0] d;
    d  = x - y;
    sx = x[2] ? int'(x) - 8 : int'(x);
    sy = y[2] ? int'(y) - 8 : int'(y);
    sr = sx - sy;
    return {d, (x < y), ((sr < -4) || (sr > 3))};
  endfunction

  task automatic run_op8(input logic [7:0] x, input logic [7:0] y);
    int n;
    logic [9:0] exp;
    sb8.push_back(model8(x, y));
    a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b want 1", busy8);
    end
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      checks++;
      if (diff8 !== held8) begin
        errors++; $display("FAIL diff_hold8: got %h want %h at cycle %0d", diff8, held8, n);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL done_latency8: got %0d want 8 (a=%h b=%h)", n, x, y);
    end
    if (done8 === 1'b1) begin
      checks++;
      if (sb8.size() == 0) begin
        errors++; $display("FAIL scoreboard8_empty: got empty want entry");
      end else begin
        exp = sb8.pop_front();
        if ({diff8, bout8, ovf8} !== exp) begin
          errors++;
          $display("FAIL result8 a=%h b=%h: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                   x, y, diff8, bout8, ovf8, exp[9:2], exp[1], exp[0]);
        end
        held8 = exp[9:2];
      end
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL done_pulse8: got done=%b busy=%b want 0 0", done8, busy8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start3 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a3 = 3'd0; b3 = 3'd0;
    held8 = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      errors++; $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                         busy8, done8, diff8, bout8, ovf8);
    end
    checks++;
    if ({busy3, done3, diff3, bout3, ovf3} !== 7'h00) begin
      errors++; $display("FAIL reset3: got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                         busy3, done3, diff3, bout3, ovf3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op8(8'h05, 8'h03);
    run_op8(8'h03, 8'h05);
    run_op8(8'h80, 8'h01);
    run_op8(8'h7F, 8'hFF);
    run_op8(8'h00, 8'h00);
  endtask

  task automatic test_back_to_back();
    int n, ndone;
    int want[3] = '{8, 18, 28};
    logic [9:0] exp;
    sb8.push_back(model8(8'h5A, 8'h3C));
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    @(negedge clk);
    n = 0; ndone = 0;
    // Operands change right after capture; the in-flight op must not notice.
    a8 = 8'h10; b8 = 8'h20;
    sb8.push_back(model8(8'h10, 8'h20));
    while (n < 40) begin
      if (done8 === 1'b1) begin
        checks++;
        if (ndone >= 3) begin
          errors++; $display("FAIL b2b_extra_done: got done at cycle %0d want none", n);
        end else begin
          if (n != want[ndone]) begin
            errors++; $display("FAIL b2b_timing: got cycle %0d want %0d", n, want[ndone]);
          end
          if (sb8.size() == 0) begin
            errors++; $display("FAIL scoreboard8_empty: got empty want entry");
          end else begin
            exp = sb8.pop_front();
            if ({diff8, bout8, ovf8} !== exp) begin
              errors++;
              $display("FAIL b2b_result%0d: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                       ndone, diff8, bout8, ovf8, exp[9:2], exp[1], exp[0]);
            end
            held8 = exp[9:2];
          end
        end
        ndone++;
      end else begin
        checks++;
        if (diff8 !== held8) begin
          errors++; $display("FAIL b2b_diff_hold: got %h want %h at cycle %0d", diff8, held8, n);
        end
      end
      if (n == 10) begin
        a8 = 8'hC3; b8 = 8'h3C;
        sb8.push_back(model8(8'hC3, 8'h3C));
      end
      if (n == 20) start8 = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (ndone != 3) begin
      errors++; $display("FAIL b2b_count: got %0d dones want 3", ndone);
    end
  endtask

  task automatic test_reset_mid_op();
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      errors++; $display("FAIL reset_mid_op: got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
                         busy8, done8, diff8, bout8, ovf8);
    end
    held8 = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++; $display("FAIL aborted_op_quiet: got done=%b busy=%b want 0 0", done8, busy8);
      end
    end
    run_op8(8'hFF, 8'hFF);
  endtask

  task automatic test_exhaustive_w3();
    int n;
    logic [4:0] exp;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        sb3.push_back(model3(3'(i), 3'(j)));
        a3 = 3'(i); b3 = 3'(j); start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 10) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (n != 3) begin
          errors++; $display("FAIL done_latency3: got %0d want 3 (a=%0d b=%0d)", n, i, j);
        end
        if (done3 === 1'b1) begin
          checks++;
          if (sb3.size() == 0) begin
            errors++; $display("FAIL scoreboard3_empty: got empty want entry");
          end else begin
            exp = sb3.pop_front();
            if ({diff3, bout3, ovf3} !== exp) begin
              errors++;
              $display("FAIL result3 a=%0d b=%0d: got diff=%0d bout=%b ovf=%b want diff=%0d bout=%b ovf=%b",
                       i, j, diff3, bout3, ovf3, exp[4:2], exp[1], exp[0]);
            end
          end
        end
        @(negedge clk);
      end
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Test sequence
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_op();
    test_exhaustive_w3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
